// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl: latches timer match edges, arbitrates by fixed
// priority and presents one IRQ + vector with ack/clear handshake.
module timer_irq_ctrl #(
  parameter int N_CH  = 4,
  parameter int VEC_W = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  evt_in,
  input  logic             mask_we,
  input  logic [N_CH-1:0]  mask_in,
  output logic [N_CH-1:0]  mask_o,
  output logic             irq_o,
  output logic [VEC_W-1:0] irq_vec_o,
  input  logic             irq_ack_i,
  output logic [N_CH-1:0]  evt_clr_o,
  output logic [N_CH-1:0]  pending_o,
  output logic [N_CH-1:0]  overrun_o,
  input  logic [N_CH-1:0]  overrun_clr_i,
  input  logic [VEC_W-1:0] cnt_sel_i,
  output logic [CNT_W-1:0] cnt_o,
  input  logic             cnt_clr_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  logic [N_CH-1:0]  evt_d;
  logic [N_CH-1:0]  mask;
  logic [N_CH-1:0]  pending;
  logic [N_CH-1:0]  overrun;
  logic [N_CH-1:0]  rise;
  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  ack_oh;
  logic [N_CH-1:0]  ovr_set;
  logic [VEC_W-1:0] vec;
  logic [VEC_W-1:0] pick;
  logic             ack;
  logic [CNT_W-1:0] cnt [N_CH];

  assign rise    = evt_in & ~evt_d;
  assign req     = pending & mask;
  assign ack     = (state == REQ) && irq_ack_i;
  assign ack_oh  = ack ? (N_CH'(1) << vec) : '0;
  assign ovr_set = rise & pending & ~ack_oh;

  assign mask_o    = mask;
  assign pending_o = pending;
  assign overrun_o = overrun;
  assign irq_vec_o = vec;
  assign cnt_o     = cnt[cnt_sel_i];

  // lowest-index enabled pending channel wins
  always_comb begin
    pick = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[i]) pick = VEC_W'(i);
    end
  end

  // edge history and mask register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evt_d <= '0;
      mask  <= '0;
    end else begin
      evt_d <= evt_in;
      if (mask_we) mask <= mask_in;
    end
  end

  // pending requests; a new edge beats a coincident ack clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= (pending & ~ack_oh) | rise;
  end

  // sticky overrun flags, set beats write-1-to-clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overrun <= '0;
    else        overrun <= (overrun & ~overrun_clr_i) | ovr_set;
  end

  // saturating per-channel edge counters, clear beats increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (cnt_clr_i)
          cnt[i] <= '0;
        else if (rise[i] && (cnt[i] != '1))
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // request handshake FSM with registered irq, vector and clear pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      irq_o     <= 1'b0;
      vec       <= '0;
      evt_clr_o <= '0;
    end else begin
      evt_clr_o <= '0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            vec   <= pick;
            irq_o <= 1'b1;
            state <= REQ;
          end
        end
        REQ: begin
          if (irq_ack_i) begin
            evt_clr_o <= ack_oh;
            irq_o     <= 1'b0;
            state     <= HOLD;
          end else if (!mask[vec]) begin
            irq_o <= 1'b0;
            state <= IDLE;
          end
        end
        HOLD: begin
          state <= IDLE;
        end
        default: begin
          irq_o <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// tb_timer_irq_ctrl: directed plan steps plus random traffic,
// checked every cycle against a behavioural model.
module tb_timer_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] evt_in = '0;
  logic       mask_we = 1'b0;
  logic [3:0] mask_in = '0;
  logic [3:0] mask_o;
  logic       irq_o;
  logic [1:0] irq_vec_o;
  logic       irq_ack_i = 1'b0;
  logic [3:0] evt_clr_o;
  logic [3:0] pending_o;
  logic [3:0] overrun_o;
  logic [3:0] overrun_clr_i = '0;
  logic [1:0] cnt_sel_i = '0;
  logic [7:0] cnt_o;
  logic       cnt_clr_i = 1'b0;

  int total = 0;
  int bad = 0;

  // model state
  bit [3:0] m_evt_d, m_mask, m_pend, m_ovr, m_clr;
  int       m_cnt [4];
  bit       m_busy, m_gap;
  int       m_vec;

  timer_irq_ctrl dut (
    .clk(clk), .reset(reset), .evt_in(evt_in),
    .mask_we(mask_we), .mask_in(mask_in), .mask_o(mask_o),
    .irq_o(irq_o), .irq_vec_o(irq_vec_o), .irq_ack_i(irq_ack_i),
    .evt_clr_o(evt_clr_o), .pending_o(pending_o),
    .overrun_o(overrun_o), .overrun_clr_i(overrun_clr_i),
    .cnt_sel_i(cnt_sel_i), .cnt_o(cnt_o), .cnt_clr_i(cnt_clr_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_evt_d = '0; m_mask = '0; m_pend = '0; m_ovr = '0; m_clr = '0;
    m_busy = 0; m_gap = 0; m_vec = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic model_step();
    bit [3:0] rise;
    bit [3:0] done;
    rise = evt_in & ~m_evt_d;
    done = '0;
    m_clr = '0;
    if (m_busy) begin
      if (irq_ack_i) begin
        done[m_vec] = 1'b1;
        m_clr = done;
        m_busy = 0;
        m_gap = 1;
      end else if (!m_mask[m_vec]) begin
        m_busy = 0;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m_pend[i] && m_mask[i]) begin
          m_busy = 1;
          m_vec = i;
          break;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (cnt_clr_i) m_cnt[i] = 0;
      else if (rise[i]) m_cnt[i] = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
    end
    m_ovr = (m_ovr & ~overrun_clr_i) | (rise & m_pend & ~done);
    m_pend = (m_pend & ~done) | rise;
    if (mask_we) m_mask = mask_in;
    m_evt_d = evt_in;
  endtask

  task automatic check_all();
    check("irq", irq_o, m_busy);
    check("vec", irq_vec_o, m_vec);
    check("clr", evt_clr_o, m_clr);
    check("pend", pending_o, m_pend);
    check("ovr", overrun_o, m_ovr);
    check("mask", mask_o, m_mask);
    check("cnt", cnt_o, m_cnt[cnt_sel_i]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    evt_in = '0; mask_we = 0; irq_ack_i = 0;
    overrun_clr_i = '0; cnt_clr_i = 0; cnt_sel_i = '0;
    reset = 0;
    #7;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1;
  endtask

  task automatic set_mask(input logic [3:0] m);
    mask_we = 1; mask_in = m;
    tick();
    mask_we = 0;
  endtask

  task automatic wait_irq(input int budget);
    for (int i = 0; i < budget && !irq_o; i++) tick();
    check("wait_irq", irq_o, 1'b1);
  endtask

  task automatic ack_once();
    irq_ack_i = 1;
    tick();
    irq_ack_i = 0;
  endtask

  initial begin
    model_reset();
    do_reset();

    // 1: single channel request and ack
    set_mask(4'b1111);
    evt_in = 4'b0100;
    tick();
    check("t1_pend", pending_o, 4'b0100);
    check("t1_irq_early", irq_o, 1'b0);
    tick();
    check("t1_irq", irq_o, 1'b1);
    check("t1_vec", irq_vec_o, 2'd2);
    ack_once();
    check("t1_clr", evt_clr_o, 4'b0100);
    check("t1_pend0", pending_o, 4'b0000);
    check("t1_gap", irq_o, 1'b0);
    tick();
    check("t1_clr_end", evt_clr_o, 4'b0000);

    // 2: two channels, priority order
    do_reset();
    set_mask(4'b1111);
    evt_in = 4'b1010;
    tick();
    tick();
    check("t2_vec1", irq_vec_o, 2'd1);
    ack_once();
    check("t2_clr1", evt_clr_o, 4'b0010);
    tick();
    tick();
    check("t2_vec3", irq_vec_o, 2'd3);
    check("t2_irq3", irq_o, 1'b1);
    ack_once();
    check("t2_clr3", evt_clr_o, 4'b1000);
    tick();

    // 3: masked pend, unmask, then mask-drop in REQ
    do_reset();
    evt_in = 4'b0001;
    tick();
    tick();
    check("t3_pend", pending_o, 4'b0001);
    check("t3_noirq", irq_o, 1'b0);
    set_mask(4'b0001);
    tick();
    check("t3_irq", irq_o, 1'b1);
    check("t3_vec", irq_vec_o, 2'd0);
    set_mask(4'b0000);
    tick();
    check("t3_drop", irq_o, 1'b0);
    check("t3_keep", pending_o, 4'b0001);

    // 4: overrun and count
    do_reset();
    cnt_sel_i = 2'd1;
    evt_in = 4'b0010; tick();
    evt_in = 4'b0000; tick();
    evt_in = 4'b0010; tick();
    check("t4_ovr", overrun_o, 4'b0010);
    check("t4_cnt", cnt_o, 8'd2);
    overrun_clr_i = 4'b0010; tick();
    overrun_clr_i = 4'b0000;
    check("t4_ovr_clr", overrun_o, 4'b0000);

    // 5: counter saturation and clear priority
    do_reset();
    cnt_sel_i = 2'd3;
    for (int i = 0; i < 300; i++) begin
      evt_in = 4'b1000; tick();
      evt_in = 4'b0000; tick();
    end
    check("t5_sat", cnt_o, 8'd255);
    evt_in = 4'b1000; cnt_clr_i = 1; tick();
    cnt_clr_i = 0;
    check("t5_clr", cnt_o, 8'd0);
    evt_in = 4'b0000; tick();

    // 6: async reset during REQ
    do_reset();
    set_mask(4'b1111);
    evt_in = 4'b0001;
    wait_irq(5);
    evt_in = 4'b0000;
    #3 reset = 0;
    #1;
    check("t6_irq", irq_o, 1'b0);
    check("t6_pend", pending_o, 4'b0000);
    check("t6_clr", evt_clr_o, 4'b0000);
    model_reset();
    @(negedge clk);
    reset = 1;
    irq_ack_i = 1;
    tick();
    irq_ack_i = 0;
    check("t6_noclr", evt_clr_o, 4'b0000);
    for (int i = 0; i < 3; i++) tick();

    // random traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      evt_in = evt_in ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      mask_we = ($urandom_range(0, 15) == 0);
      mask_in = 4'($urandom_range(0, 15));
      irq_ack_i = irq_o ? ($urandom_range(0, 2) == 0)
                        : ($urandom_range(0, 9) == 0);
      overrun_clr_i = ($urandom_range(0, 7) == 0) ?
                      4'($urandom_range(0, 15)) : 4'b0000;
      cnt_clr_i = ($urandom_range(0, 63) == 0);
      cnt_sel_i = 2'($urandom_range(0, 3));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_irq_ctrl.md
Name: timer_irq_ctrl

Overview:
- Interrupt controller directly downstream of the 32-bit match timer.
- Consumes the timer's per-channel match interrupt flags (IR[3:0]) and latches their rising edges as pending requests.
- Applies a per-channel enable mask, picks one request by fixed priority, and presents it to the CPU as a single IRQ plus vector with an acknowledge handshake.
- On acknowledge, pulses a clear back to the timer for the serviced channel; also keeps overrun flags and per-channel event counters.

Parameters:
- N_CH, 4, number of match channels (timer IR bits consumed).
- VEC_W, 2, vector width, equal to clog2(N_CH).
- CNT_W, 8, width of each per-channel saturating event counter.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- evt_in  in  N_CH  timer IR flags, synchronous to clk, level.
- mask_we  in  1  write strobe for mask register.
- mask_in  in  N_CH  new mask value, 1 = channel enabled.
- mask_o  out  N_CH  current mask register.
- irq_o  out  1  interrupt request to CPU.
- irq_vec_o  out  VEC_W  channel index of the request being presented.
- irq_ack_i  in  1  CPU acknowledge, one-cycle pulse.
- evt_clr_o  out  N_CH  one-hot, one-cycle clear pulse to the timer IR bit.
- pending_o  out  N_CH  pending register.
- overrun_o  out  N_CH  sticky overrun flags.
- overrun_clr_i  in  N_CH  write-1-to-clear for overrun_o.
- cnt_sel_i  in  VEC_W  counter readout select.
- cnt_o  out  CNT_W  event count of the selected channel, combinational mux.
- cnt_clr_i  in  1  clears all event counters.

Behaviour:
- Reset (reset=0, async): mask=0, pending=0, overrun=0, counters=0, evt_d=0, state=IDLE, irq_o=0, irq_vec_o=0, evt_clr_o=0.
- Edge detect: rise[i] = evt_in[i] & ~evt_d[i]; evt_d <= evt_in every cycle.
- Pending set: on rise[i], pending[i] <= 1 at that posedge, independent of mask.
- Overrun: rise[i] while pending[i] is already 1 and not being cleared that cycle -> overrun[i] <= 1.
  - Overrun is sticky until overrun_clr_i[i]=1.
  - If set and clear coincide, set wins.
- Counters: rise[i] increments cnt[i], saturating at 2^CNT_W-1.
  - cnt_clr_i zeroes all counters; it wins over a coincident increment.
- Mask: mask_we=1 loads mask_in at the posedge.
- FSM IDLE:
  - If (pending & mask) != 0, latch vec = lowest set index and go to REQ.
  - irq_o=0 in IDLE.
- FSM REQ:
  - irq_o=1 and irq_vec_o=vec, both registered and stable for the whole of REQ.
  - irq_ack_i=1: clear pending[vec], pulse evt_clr_o[vec] for exactly one cycle (registered), go to HOLD.
  - mask[vec] cleared while in REQ with no ack: go to IDLE, irq_o drops next cycle, pending[vec] retained.
  - Ack and mask-clear in the same cycle: ack wins.
- FSM HOLD: one cycle with irq_o=0, then go to IDLE. This guarantees a low gap between requests.
- Ack outside REQ is ignored: no state change, no clear pulse.
- Simultaneous rise[vec] and ack in the same cycle: pending[vec] stays 1, no overrun; it is re-presented after HOLD.
- Latency:
  - evt_in rise sampled at edge k -> pending visible after k -> irq_o=1 after edge k+1.
  - Ack at edge m -> evt_clr_o high after m -> earliest next irq_o=1 after edge m+2.
- Priority: channel 0 is highest. Arbitration happens only in IDLE; a higher-priority arrival during REQ does not preempt.
- reset=0 mid-handshake: everything returns to reset values immediately, with no clear pulse emitted.

Test Plan:
1. Reset, mask=4'b1111, evt_in[2] 0->1 -> pending=4'b0100, irq_o=1 two edges later, irq_vec_o=2. Ack -> evt_clr_o=4'b0100 for one cycle, pending=0, irq_o low for at least 1 cycle.
2. evt_in=4'b1010 rising together, mask=4'b1111 -> vec 1 served first. After ack and HOLD, vec 3 is presented; two evt_clr_o pulses, 4'b0010 then 4'b1000.
3. mask=0, evt_in[0] rises -> pending[0]=1, irq_o stays 0. mask_we with 4'b0001 -> irq_o=1 two edges later, vec 0. Clear mask during REQ -> irq_o=0, pending[0] still 1.
4. evt_in[1] toggles 0->1->0->1 with no ack -> overrun_o[1]=1, cnt_o (sel=1)=2. overrun_clr_i=4'b0010 -> overrun_o=0.
5. evt_in[3] toggled 300 times, CNT_W=8 -> cnt_o saturates at 255. cnt_clr_i on the same cycle as a rise -> 0.
6. Assert reset=0 while in REQ, asynchronously between edges -> irq_o, pending, and evt_clr_o are 0 immediately, and no clear pulse appears after reset is released.
